// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display path: digit count, special
// display codes, and the active-low segment pattern for every glyph.
// Segment bit order everywhere is {g,f,e,d,c,b,a}, where 0 lights a segment.
package display_pkg;

    localparam int NUM_DIGITS = 8;

    // Display codes with a fixed meaning beyond the hex range
    localparam logic [5:0] CODE_H     = 6'h10;
    localparam logic [5:0] CODE_L     = 6'h11;
    localparam logic [5:0] CODE_P     = 6'h12;
    localparam logic [5:0] CODE_U     = 6'h13;
    localparam logic [5:0] CODE_R     = 6'h14;
    localparam logic [5:0] CODE_N     = 6'h15;
    localparam logic [5:0] CODE_O     = 6'h16;
    localparam logic [5:0] CODE_DASH  = 6'h23;
    localparam logic [5:0] CODE_BLANK = 6'h3F;

    // Hex digits
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    // Letter glyphs
    localparam logic [6:0] SEG_H = 7'b0001001;
    localparam logic [6:0] SEG_L = 7'b1000111;
    localparam logic [6:0] SEG_P = 7'b0001100;
    localparam logic [6:0] SEG_U = 7'b1000001;
    localparam logic [6:0] SEG_R = 7'b0101111;
    localparam logic [6:0] SEG_N = 7'b0101011;
    localparam logic [6:0] SEG_O = 7'b0100011;

    // Punctuation / blank
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low one-hot anode pattern selecting a single digit
    function automatic logic [NUM_DIGITS-1:0] anode_select_n(input logic [2:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/glyph_decoder.sv
// Purely combinational map from a 6-bit display code to active-low segments.
// Anything not explicitly listed renders as blank.
module glyph_decoder
    import display_pkg::*;
(
    input  logic [5:0] i_code,
    output logic [6:0] o_seg
);

    // Table lookup with blank as the fallback for unlisted codes
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_code)
            6'h00:      o_seg = SEG_0;
            6'h01:      o_seg = SEG_1;
            6'h02:      o_seg = SEG_2;
            6'h03:      o_seg = SEG_3;
            6'h04:      o_seg = SEG_4;
            6'h05:      o_seg = SEG_5;
            6'h06:      o_seg = SEG_6;
            6'h07:      o_seg = SEG_7;
            6'h08:      o_seg = SEG_8;
            6'h09:      o_seg = SEG_9;
            6'h0A:      o_seg = SEG_A;
            6'h0B:      o_seg = SEG_B;
            6'h0C:      o_seg = SEG_C;
            6'h0D:      o_seg = SEG_D;
            6'h0E:      o_seg = SEG_E;
            6'h0F:      o_seg = SEG_F;
            CODE_H:     o_seg = SEG_H;
            CODE_L:     o_seg = SEG_L;
            CODE_P:     o_seg = SEG_P;
            CODE_U:     o_seg = SEG_U;
            CODE_R:     o_seg = SEG_R;
            CODE_N:     o_seg = SEG_N;
            CODE_O:     o_seg = SEG_O;
            CODE_DASH:  o_seg = SEG_DASH;
            default:    o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed eight-digit seven-segment driver. A prescaler divides the
// clock into digit slots; each slot opens with a short all-anodes-off dead
// time to suppress ghosting. The eight codes are snapshotted only at frame
// boundaries so a frame never mixes old and new values. Digits flagged in
// blink_mask are hidden during alternate blink half-periods.
module display_scanner
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int DEAD_CYCLES  = 16,
    parameter int BLINK_FRAMES = 64
)(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [5:0]            d1,
    input  logic [5:0]            d2,
    input  logic [5:0]            d3,
    input  logic [5:0]            d4,
    input  logic [5:0]            d5,
    input  logic [5:0]            d6,
    input  logic [5:0]            d7,
    input  logic [5:0]            d8,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_DEAD = PRE_W'(DEAD_CYCLES);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0]      r_pre;
    logic [2:0]            r_idx;
    logic [FRM_W-1:0]      r_frame;
    logic                  r_blink_phase;
    logic [5:0]            r_snap [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;

    logic [5:0]            w_codes [NUM_DIGITS];
    logic                  w_slot_tick;
    logic                  w_frame_tick;
    logic                  w_dead;
    logic                  w_hide;
    logic [5:0]            w_cur_code;
    logic [6:0]            w_glyph;

    // d1 feeds digit 0 (an[0]) through d8 feeding digit 7
    assign w_codes[0] = d1;
    assign w_codes[1] = d2;
    assign w_codes[2] = d3;
    assign w_codes[3] = d4;
    assign w_codes[4] = d5;
    assign w_codes[5] = d6;
    assign w_codes[6] = d7;
    assign w_codes[7] = d8;

    assign w_slot_tick  = (r_pre == PRE_LAST);
    assign w_frame_tick = w_slot_tick && (r_idx == 3'd7);
    assign w_dead       = (r_pre < PRE_DEAD);
    assign w_hide       = blink_mask[r_idx] & r_blink_phase;
    assign w_cur_code   = r_snap[r_idx];

    glyph_decoder u_glyph (
        .i_code (w_cur_code),
        .o_seg  (w_glyph)
    );

    // Prescaler and digit index: one slot every REFRESH_DIV cycles, idx wraps 7->0
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (w_slot_tick) begin
            r_pre <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Frame counter and blink phase advance only on frame boundaries
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_frame       <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_frame_tick) begin
            if (r_frame == FRM_LAST) begin
                r_frame       <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame <= r_frame + FRM_W'(1);
            end
        end
    end

    // Snapshot all codes together at the frame boundary for coherent frames
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_snap[i] <= CODE_BLANK;
            end
        end else if (w_frame_tick) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_snap[i] <= w_codes[i];
            end
        end
    end

    // Output register: anodes gated by dead time and blink, segments always driven
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= (w_dead || w_hide) ? '1 : anode_select_n(r_idx);
            r_seg <= w_glyph;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner. The driver advances a cycle count k since reset
// release and predicts each registered output from arithmetic on k (slot,
// digit, frame, blink half-period) plus the codes it recorded at each frame
// boundary; predictions go into a queue that a monitor drains and compares.
module tb_display_scanner;

    localparam int RD = 4;
    localparam int DC = 1;
    localparam int BF = 2;
    localparam int FR = 8 * RD;

    typedef struct packed {
        logic [7:0]  an;
        logic [6:0]  seg;
        logic [31:0] k;
    } exp_t;

    logic       clock;
    logic       reset;
    logic [5:0] d_in [8];
    logic [7:0] blink_mask;
    logic [7:0] an;
    logic [6:0] seg;

    int   checks   = 0;
    int   failures = 0;
    int   k        = 0;
    exp_t sb [$];

    logic [6:0] glyph_tab [64];
    logic [5:0] fcodes [256][8];

    display_scanner #(
        .REFRESH_DIV  (RD),
        .DEAD_CYCLES  (DC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .d1         (d_in[0]),
        .d2         (d_in[1]),
        .d3         (d_in[2]),
        .d4         (d_in[3]),
        .d5         (d_in[4]),
        .d6         (d_in[5]),
        .d7         (d_in[6]),
        .d8         (d_in[7]),
        .blink_mask (blink_mask),
        .an         (an),
        .seg        (seg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference glyph table: blank everywhere except listed codes
    task automatic init_glyphs();
        logic [6:0] hex_g [16];
        hex_g = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        for (int i = 0; i < 64; i++) glyph_tab[i] = 7'h7F;
        for (int i = 0; i < 16; i++) glyph_tab[i] = hex_g[i];
        glyph_tab[6'h10] = 7'h09;   // H
        glyph_tab[6'h11] = 7'h47;   // L
        glyph_tab[6'h12] = 7'h0C;   // P
        glyph_tab[6'h13] = 7'h41;   // U
        glyph_tab[6'h14] = 7'h2F;   // r
        glyph_tab[6'h15] = 7'h2B;   // n
        glyph_tab[6'h16] = 7'h23;   // o
        glyph_tab[6'h23] = 7'h3F;   // dash
    endtask

    // Predict the output registered at the next rising edge, record codes if
    // that edge is a frame boundary, then move to the next falling edge.
    task automatic tick();
        exp_t       e;
        int         pre, idx, f, ph;
        logic [5:0] code;
        pre = k % RD;
        idx = (k / RD) % 8;
        f   = k / FR;
        ph  = (f / BF) % 2;
        e.an = 8'hFF;
        if (!(pre < DC) && !(blink_mask[idx] && ph == 1)) e.an[idx] = 1'b0;
        code  = (f == 0) ? 6'h3F : fcodes[f][idx];
        e.seg = glyph_tab[code];
        e.k   = k;
        sb.push_back(e);
        if ((k + 1) % FR == 0 && (k + 1) / FR < 256) begin
            for (int j = 0; j < 8; j++) fcodes[(k + 1) / FR][j] = d_in[j];
        end
        @(negedge clock);
        k++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_until(input int phase);
        while (k % FR != phase) tick();
    endtask

    task automatic random_cycles(input int n);
        repeat (n) begin
            if ($urandom_range(0, 7) == 0) d_in[$urandom_range(0, 7)] = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 39) == 0) blink_mask = 8'($urandom);
            tick();
        end
    endtask

    // Reset asserted at a falling edge: outputs must clear immediately and stay cleared
    task automatic do_reset();
        reset = 1'b0;
        #1;
        checks++;
        if (an !== 8'hFF || seg !== 7'h7F) begin
            failures++;
            $display("FAIL reset_async an=%h seg=%h required an=ff seg=7f", an, seg);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if (an !== 8'hFF || seg !== 7'h7F) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d an=%h seg=%h required an=ff seg=7f", i, an, seg);
            end
        end
        reset = 1'b1;
        k = 0;
    endtask

    // Monitor: each cycle out of reset, pop the oldest prediction and compare
    always @(posedge clock) begin
        #1;
        if (reset === 1'b1 && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg) begin
                failures++;
                $display("FAIL scan k=%0d an=%h seg=%h required an=%h seg=%h",
                         e.k, an, seg, e.an, e.seg);
            end else begin
                $display("txn k=%0d an=%h seg=%h ok", e.k, an, seg);
            end
        end
    end

    initial begin
        init_glyphs();
        for (int i = 0; i < 8; i++) d_in[i] = 6'h00;
        blink_mask = 8'h00;
        reset = 1'b0;
        @(negedge clock);
        do_reset();

        // Scan order with all-zero codes: blank first frame, then 0 on every digit
        run(2 * FR);

        // Coherency: d3 changes while digit 5 is being shown
        run_until(5 * RD + 1);
        d_in[2] = 6'h01;
        run(2 * FR);

        // Decode: dash, explicit blank, unlisted code, plus a letter
        run_until(3);
        d_in[0] = 6'h23;
        d_in[1] = 6'h3F;
        d_in[2] = 6'h2A;
        d_in[3] = 6'h10;
        run(2 * FR);

        // Blink on digit 0 across several blink periods
        blink_mask = 8'h01;
        run(9 * FR);
        blink_mask = 8'h00;

        // Boundary: change just before the boundary edge is captured,
        // change just after it waits a whole frame
        run_until(FR - 1);
        d_in[7] = 6'h05;
        tick();
        d_in[7] = 6'h09;
        run(3 * FR);

        // Randomized codes and blink masks
        random_cycles(24 * FR + 13);

        // Reset in the middle of a scan, then resume
        do_reset();
        random_cycles(4 * FR);

        @(posedge clock);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed driver for the board's eight 7-segment digits. Consumes the eight 6-bit display codes `d1`..`d8` produced by the display manager and drives shared active-low segment lines and per-digit active-low anodes. Codes are snapshotted once per frame so that no frame ever shows a mix of old and new codes. The block adds anti-ghosting dead time and per-digit blinking.

## Interface
- `REFRESH_DIV`, 50000: clock cycles per digit slot; must be ≥ 2.
- `DEAD_CYCLES`, 16: cycles at the start of each slot with all anodes off; must be < `REFRESH_DIV`.
- `BLINK_FRAMES`, 64: frames per blink half-period; must be ≥ 1.

- `clock`  input  1  sole clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `d1`..`d8`  input  6 each  display codes; `d1` drives digit 0 (`an[0]`), `d8` drives digit 7.
- `blink_mask`  input  8  bit k=1 makes digit k blink.
- `an`  output  8  anodes, active-low, at most one low at a time.
- `seg`  output  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation
- **Code map** (package glyph table):
  - 6'h00–6'h0F: hex digits, for example 0 = 7'b1000000, 1 = 7'b1111001.
  - 6'h23: dash, 7'b0111111.
  - 6'h3F and every unlisted code: blank, 7'b1111111.
  - The remaining letter glyphs are listed in the package.
- **Prescaler** `pre` counts 0..`REFRESH_DIV`-1 and then wraps. A slot tick occurs when `pre` = `REFRESH_DIV`-1.
- **Digit index** `idx` (3 bits) increments on each slot tick, 7→0 wrap.
- **Frame boundary**: the slot tick taken while `idx` = 7. On this tick:
  - All eight codes are captured into snapshot registers `snap[0..7]`.
  - The frame counter advances, wrapping at `BLINK_FRAMES`-1.
  - If the frame counter wraps, `blink_phase` toggles.
- Codes are sampled **only** at frame boundaries. Input changes between boundaries are invisible until the next boundary.
- **Output computation**, registered each cycle:
  - `dead` = (`pre` < `DEAD_CYCLES`).
  - `hide` = `blink_mask[idx]` & `blink_phase`.
  - `an` = 8'hFF if `dead` or `hide`, otherwise ~(8'b1 << `idx`).
  - `seg` = glyph(`snap[idx]`), independent of `dead` and `hide`.
- `blink_mask` is sampled live, every cycle, not snapshotted.
- **Reset values** (asynchronous, while `reset` = 0):
  - `pre` = 0, `idx` = 0, frame counter = 0, `blink_phase` = 0.
  - `snap[*]` = 6'h3F.
  - `an` = 8'hFF, `seg` = 7'h7F.
- **Reset mid-frame**: all state returns to reset values immediately. After release, scanning restarts at digit 0, slot start. The first real codes appear after the first frame boundary.

## Timing
- Outputs lag `pre`/`idx` state by 1 cycle (single output register stage).
- Per digit slot:
  - `an` high for `DEAD_CYCLES` cycles.
  - `an` low (one bit) for `REFRESH_DIV`-`DEAD_CYCLES` cycles.
- Frame = 8·`REFRESH_DIV` cycles. Blink period = 2·`BLINK_FRAMES` frames.
- Change-to-display latency: a code change becomes visible on the first frame boundary after it. Worst case is one frame plus 1 cycle, plus `DEAD_CYCLES` before the anode enables.
- Codes are sampled on the rising edge at which the frame-boundary tick is taken. A change on that same edge is not captured.
- First cycle after reset release: `an` = 8'hFF (dead time, `pre` = 0).

## Structure
- Shared package `display_pkg` holds:
  - glyph localparams (`CODE_DASH` = 6'h23, `CODE_BLANK` = 6'h3F);
  - a seven-segment constant for each glyph;
  - `NUM_DIGITS` = 8.
- One sub-module, `glyph_decoder`: a purely combinational 6-bit code to 7-bit active-low segment map. It is instantiated once, on the `snap[idx]` mux output.
- All counters and snapshot registers live in `display_scanner`. The prescaler width is $clog2(`REFRESH_DIV`).

## Test plan
Parameters for all scenarios: `REFRESH_DIV`=4, `DEAD_CYCLES`=1, `BLINK_FRAMES`=2.

- **Reset**: assert `reset`=0 mid-scan → `an`=8'hFF and `seg`=7'h7F the same cycle. Hold 5 cycles, release → `an`=8'hFF for 1 cycle, then 8'hFE with `seg`=7'h7F (blank snapshot).
- **Scan order**: all `d`=6'h00 from reset; after the first boundary (cycle 32) → each slot shows `an` = FE, FD, FB, … 7F in sequence. Each slot has 1 cycle of FF then 3 cycles of the digit, with `seg`=7'b1000000.
- **Snapshot coherency**: change `d3` from 6'h00 to 6'h01 mid-frame (during digit 5) → digit 2 shows 7'b1000000 for the rest of that frame and 7'b1111001 only from the next frame.
- **Decode**: `d1`=6'h23, `d2`=6'h3F, `d3`=6'h2A (unlisted) → digit 0 `seg`=7'b0111111; digits 1 and 2 `seg`=7'b1111111.
- **Blink**: `blink_mask`=8'h01 → digit 0 anode enabled for 2 frames, then `an[0]` held 1 for 2 frames, repeating. Other digits are unaffected.
- **Boundary**: change `d8` on the exact edge of the frame tick → the old value is captured and the new value appears one frame later.
